sc_fifo_burst_rdr: RTL and testbench

Read-side controller for the single-clock FIFO. It drains the FIFO through its pop interface and presents the words as fixed-length bursts on a valid/ready stream, marking the first word of each burst with sop and the last with eop. It sits between the FIFO and the downstream burst consumer. It never pops an empty FIFO, so the FIFO's read-empty error can never fire from this side.

---
 rtl/sc_fifo_burst_rdr_pkg.sv | 16 +
 rtl/sc_fifo_burst_rdr_oreg.sv | 36 +++
 rtl/sc_fifo_burst_rdr.sv | 119 +++++++++++
 tb/tb_sc_fifo_burst_rdr.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_burst_rdr_pkg.sv
// Shared types and helpers for the FIFO burst reader.
// State encoding and counter width helper.
package sc_fifo_burst_rdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    // idx/len must hold a full FIFO level (0..2**PTRW)
    function automatic int cnt_w(input int ptrw);
        return ptrw + 1;
    endfunction

endpackage

// File: rtl/sc_fifo_burst_rdr_oreg.sv
// Output register stage of the FIFO burst reader.
// Holds one stream beat: load on pop, clear on handshake, else hold.
module sc_fifo_burst_rdr_oreg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    input  logic          sop_in,
    input  logic          eop_in,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic          sop,
    output logic          eop
);

    // Beat register: a load wins over a concurrent handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            valid <= 1'b1;
            sop   <= sop_in;
            eop   <= eop_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sc_fifo_burst_rdr.sv
// Read-side burst controller for the single-clock FIFO.
// Partial flush on idle timeout: SC_FIFO_BURST_RDR_TIMEOUT_EN.
module sc_fifo_burst_rdr
    import sc_fifo_burst_rdr_pkg::*;
#(
    parameter int             DW        = 32,
    parameter int             PTRW      = 8,
    parameter int             BURST_LEN = 16,
    parameter int             TOW       = 8,
    parameter logic [TOW-1:0] TIMEOUT   = 8'd200
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DW-1:0]   fifo_dataout,
    input  logic            fifo_empty,
    input  logic [PTRW:0]   fifo_entry_used,
    output logic            fifo_rd_op,
    output logic [DW-1:0]   m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_sop,
    output logic            m_eop,
    output logic            busy
);

    localparam int            CW = cnt_w(PTRW);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    state_t        state;
    logic [CW-1:0] idx;
    logic [CW-1:0] len;
    logic [CW-1:0] flush_len;
    logic          pop;
    logic          last;
    logic          full_lvl;
    logic          go_flush;

    assign full_lvl   = fifo_entry_used >= BL;
    assign last       = idx == (len - 1'b1);
    assign pop        = (state != IDLE) & ~fifo_empty
                      & (~m_valid | m_ready);
    assign fifo_rd_op = pop;
    assign busy       = state != IDLE;

`ifdef SC_FIFO_BURST_RDR_TIMEOUT_EN
    logic [TOW-1:0] to_cnt;
    logic           timeout_hit;

    assign timeout_hit = to_cnt == TIMEOUT;
    assign go_flush    = (state == IDLE) & ~full_lvl & timeout_hit
                       & (fifo_entry_used != '0);
    assign flush_len   = fifo_entry_used;

    // Idle timer: counts while a partial burst waits, saturates at TIMEOUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state != IDLE || go_flush || full_lvl
                     || fifo_entry_used == '0) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_to;

    assign unused_to = ^TIMEOUT;
    assign go_flush  = 1'b0;
    assign flush_len = BL;
`endif

    // Burst sequencer: start, count beats, return to IDLE on last pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_lvl) begin
                        state <= BURST;
                        len   <= BL;
                        idx   <= '0;
                    end else if (go_flush) begin
                        state <= FLUSH;
                        len   <= flush_len;
                        idx   <= '0;
                    end
                end
                BURST, FLUSH: begin
                    if (pop) begin
                        idx <= idx + 1'b1;
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sc_fifo_burst_rdr_oreg #(
        .DW(DW)
    ) u_oreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pop),
        .data_in (fifo_dataout),
        .sop_in  (idx == '0),
        .eop_in  (last),
        .ready   (m_ready),
        .data    (m_data),
        .valid   (m_valid),
        .sop     (m_sop),
        .eop     (m_eop)
    );

endmodule

// File: tb/tb_sc_fifo_burst_rdr.sv
// Bench for sc_fifo_burst_rdr with a behavioural FIFO and scoreboard.
// Honours SC_FIFO_BURST_RDR_TIMEOUT_EN for the timeout scenario.
module tb_sc_fifo_burst_rdr;

    localparam int DW   = 32;
    localparam int PTRW = 4;
    localparam int BL   = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] fifo_dataout;
    logic          fifo_empty;
    logic [PTRW:0] fifo_entry_used;
    logic          fifo_rd_op;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sop;
    logic          m_eop;
    logic          busy;

    logic          push;
    logic [DW-1:0] din;
    logic          dir_ready;
    logic          rnd_mode;
    logic          rnd_r;

    int n_chk;
    int n_fail;
    int cyc;
    int pop_seen;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } acc_t;

    beat_t exp_q[$];
    acc_t  acc_q[$];

    sc_fifo_burst_rdr #(
        .DW        (DW),
        .PTRW      (PTRW),
        .BURST_LEN (BL),
        .TOW       (8),
        .TIMEOUT   (8'd8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fifo_dataout    (fifo_dataout),
        .fifo_empty      (fifo_empty),
        .fifo_entry_used (fifo_entry_used),
        .fifo_rd_op      (fifo_rd_op),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_sop           (m_sop),
        .m_eop           (m_eop),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    // Behavioural single-clock FIFO
    logic [DW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wp;
    logic [PTRW-1:0] rp;
    logic [PTRW:0]   fcnt;
    logic            rd_err;
    logic            f_wr;
    logic            f_rd;

    assign f_wr            = push && (fcnt != DEPTH[PTRW:0]);
    assign f_rd            = fifo_rd_op && (fcnt != '0);
    assign fifo_dataout    = mem[rp];
    assign fifo_empty      = fcnt == '0;
    assign fifo_entry_used = fcnt;
    assign m_ready         = rnd_mode ? rnd_r : dir_ready;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (f_wr) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (f_rd) rp <= rp + 1'b1;
            fcnt <= fcnt + {{PTRW{1'b0}}, f_wr} - {{PTRW{1'b0}}, f_rd};
            if (fifo_rd_op && fcnt == '0) rd_err <= 1'b1;
        end
    end

    task automatic chk(input string tag, input longint got,
                       input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want,
                     $time);
        end
    endtask

    // Scoreboard and stream-rule monitor, sampled mid-cycle
    logic          bp_pend;
    logic [DW-1:0] bp_data;

    always @(negedge clk) begin
        cyc++;
        if (fifo_rd_op) pop_seen++;
        if (!reset_n) begin
            bp_pend = 1'b0;
        end else begin
            if (bp_pend) begin
                chk("bp_hold_data", m_data, bp_data);
                chk("bp_hold_valid", m_valid, 1);
            end
            if (fifo_rd_op) chk("pop_nonempty", fifo_empty, 0);
            bp_pend = m_valid && !m_ready;
            if (bp_pend) begin
                bp_data = m_data;
                chk("bp_no_pop", fifo_rd_op, 0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", m_data, -1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_sop", m_sop, e.s);
                    chk("beat_eop", m_eop, e.e);
                end
                acc_q.push_back('{m_data, cyc});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_r = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_raw(input logic [DW-1:0] w);
        @(posedge clk);
        #1;
        push = 1'b1;
        din  = w;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input int pos,
                             input int blen);
        push_raw(w);
        exp_q.push_back('{w, pos == 0, pos == blen - 1});
    endtask

    task automatic push_end();
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < max) begin
            @(negedge clk);
            t++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int n, input int max);
        int t;
        t = 0;
        while (acc_q.size() < n && t < max) begin
            @(posedge clk);
            t++;
        end
        chk("wait_beats", longint'(acc_q.size() >= n), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push    = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        pop_seen  = 0;
        rd_err    = 1'b0;
        bp_pend   = 1'b0;
        bp_data   = '0;
        reset_n   = 1'b0;
        push      = 1'b0;
        din       = '0;
        dir_ready = 1'b1;
        rnd_mode  = 1'b0;
        rnd_r     = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_sop", m_sop, 0);
        chk("rst_eop", m_eop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_op", fifo_rd_op, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_pop", pop_seen, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", m_valid, 0);

        // single full burst and its latency
        acc_q.delete();
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i, i, BL);
        push_end();
        @(negedge clk);
        chk("lat_n0_busy", busy, 0);
        chk("lat_n0_valid", m_valid, 0);
        @(negedge clk);
        chk("lat_n1_busy", busy, 1);
        chk("lat_n1_pop", fifo_rd_op, 1);
        chk("lat_n1_valid", m_valid, 0);
        @(negedge clk);
        chk("lat_n2_valid", m_valid, 1);
        chk("lat_n2_sop", m_sop, 1);
        chk("lat_n2_data", m_data, 32'hA0);
        wait_drain("drain_full", 50);
        chk("full_beats", acc_q.size(), 4);
        if (acc_q.size() == 4)
            chk("full_tput", acc_q[3].c - acc_q[0].c, 3);

        // back-to-back bursts
        acc_q.delete();
        for (int i = 0; i < 8; i++) push_word(i, i % BL, BL);
        push_end();
        wait_drain("drain_b2b", 80);
        chk("b2b_beats", acc_q.size(), 8);
        if (acc_q.size() == 8) begin
            chk("b2b_tput", acc_q[3].c - acc_q[0].c, 3);
            chk("b2b_gap", acc_q[4].c - acc_q[3].c, 2);
            chk("b2b_tput2", acc_q[7].c - acc_q[4].c, 3);
        end

        // backpressure mid-burst
        acc_q.delete();
        for (int i = 0; i < 4; i++) push_word(32'hB0 + i, i, BL);
        push_end();
        wait_beats(2, 50);
        #1;
        dir_ready = 1'b0;
        begin
            int p0;
            p0 = pop_seen;
            repeat (5) @(posedge clk);
            chk("bp_pops", pop_seen - p0, 0);
            chk("bp_beats", acc_q.size(), 2);
        end
        #1;
        dir_ready = 1'b1;
        wait_drain("drain_bp", 50);
        chk("bp_total", acc_q.size(), 4);

        // partial burst and idle timeout
        acc_q.delete();
`ifdef SC_FIFO_BURST_RDR_TIMEOUT_EN
        push_word(32'h55, 0, 2);
        push_word(32'h66, 1, 2);
        push_end();
        repeat (8) @(negedge clk);
        chk("to_early", acc_q.size(), 0);
        wait_drain("drain_to", 60);
        chk("to_beats", acc_q.size(), 2);
`else
        push_raw(32'h55);
        push_raw(32'h66);
        push_end();
        repeat (100) @(negedge clk);
        chk("no_to_beats", acc_q.size(), 0);
        chk("no_to_level", fcnt, 2);
        chk("no_to_busy", busy, 0);
        do_reset();
`endif

        // reset mid-burst
        acc_q.delete();
        for (int i = 0; i < 4; i++) push_word(32'hC0 + i, i, BL);
        push_end();
        wait_beats(2, 50);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pop", fifo_rd_op, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", m_valid, 0);

        // randomized groups under random backpressure
        acc_q.delete();
        rnd_mode = 1'b1;
        for (int g = 0; g < 20; g++) begin
            int t;
            repeat ($urandom_range(0, 10)) @(posedge clk);
            t = 0;
            while (fcnt > 12 && t < 200) begin
                @(posedge clk);
                t++;
            end
            for (int i = 0; i < 4; i++) push_word($urandom, i, BL);
            push_end();
        end
        wait_drain("drain_rnd", 1000);
        chk("rnd_beats", acc_q.size(), 80);
        rnd_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("rd_empty_err", rd_err, 0);
        chk("final_level", fcnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
